riscv_enc: RTL and testbench

Instruction encoder and IMEM program loader. It is the inverse of the ID-stage decoder: it takes decoded fields (class, alu_op code, branch funct3, rd/rs1/rs2, imm) and packs a legal RV32 instruction word. Each word is emitted on a valid/ready stream with a word address, for writing anomaly-detection kernels into instruction memory at boot. Contract: any word it emits, decoded by riscv_id, yields the same alu_op, rd and immediate.

---
 rtl/riscv_enc_pkg.sv | 72 +++++++
 rtl/riscv_enc_if.sv | 33 +++
 rtl/riscv_enc_pack.sv | 70 +++++++
 rtl/riscv_enc.sv | 138 +++++++++++++
 tb/tb_riscv_enc.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_enc_pkg.sv
// Shared encoding constants for the RV32 instruction encoder/loader.
// The ALU op codes and class values match those used by riscv_id.
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    CLS_OPIMM  = 3'd0,
    CLS_OP     = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5,
    CLS_JALR   = 3'd6,
    CLS_BAD    = 3'd7
  } enc_cls_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } enc_state_e;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_AND = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_MUL = 4'd10;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  function automatic logic [2:0] alu_funct3(input logic [3:0] op);
    logic [2:0] f3;
    case (op)
      ALU_AND: f3 = F3_AND;
      ALU_OR:  f3 = F3_OR;
      ALU_XOR: f3 = F3_XOR;
      ALU_SLL: f3 = F3_SLL;
      ALU_SRL: f3 = F3_SRL;
      default: f3 = F3_ADD;
    endcase
    return f3;
  endfunction

  // True when v survives truncation to a 'bits'-wide two's-complement field.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (bits - 1));
    return (hi == 32'd0) || (hi == '1);
  endfunction

endpackage

// File: rtl/riscv_enc_if.sv
// Field-bundle input stream and instruction-word output stream of riscv_enc.
interface riscv_enc_if #(parameter int AW = 32) ();

  logic          enc_valid;
  logic          enc_ready;
  logic [2:0]    enc_cls;
  logic [3:0]    enc_alu_op;
  logic [2:0]    enc_br_f3;
  logic [4:0]    enc_rd;
  logic [4:0]    enc_rs1;
  logic [4:0]    enc_rs2;
  logic [31:0]   enc_imm;

  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;

  modport master (
    output enc_valid, enc_cls, enc_alu_op, enc_br_f3, enc_rd, enc_rs1, enc_rs2, enc_imm,
    input  enc_ready,
    input  out_valid, out_instr, out_addr,
    output out_ready
  );

  modport slave (
    input  enc_valid, enc_cls, enc_alu_op, enc_br_f3, enc_rd, enc_rs1, enc_rs2, enc_imm,
    output enc_ready,
    output out_valid, out_instr, out_addr,
    input  out_ready
  );

endinterface

// File: rtl/riscv_enc_pack.sv
// Combinational field packer: decoded fields -> RV32 instruction word plus legality flag.
module riscv_enc_pack
  import riscv_enc_pkg::*;
(
  input  logic [2:0]  cls_i,
  input  logic [3:0]  alu_op_i,
  input  logic [2:0]  br_f3_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        legal_o
);

  logic       isShift;
  logic [2:0] aluF3;
  logic [6:0] opF7;

  always_comb begin
    instr_o = '0;
    legal_o = 1'b0;
    isShift = (alu_op_i == ALU_SLL) || (alu_op_i == ALU_SRL);
    aluF3   = alu_funct3(alu_op_i);
    opF7    = F7_ZERO;
    if (alu_op_i == ALU_SUB) opF7 = F7_SUB;
    else if (alu_op_i == ALU_MUL) opF7 = F7_MUL;

    case (enc_cls_e'(cls_i))
      CLS_OPIMM: begin
        legal_o = (alu_op_i <= ALU_SRL) &&
                  (isShift ? (imm_i[31:5] == 27'd0) : fits_signed(imm_i, 12));
        if (isShift) instr_o = {F7_ZERO, imm_i[4:0], rs1_i, aluF3, rd_i, OPC_OPIMM};
        else         instr_o = {imm_i[11:0], rs1_i, aluF3, rd_i, OPC_OPIMM};
      end
      CLS_OP: begin
        legal_o = (alu_op_i <= ALU_SUB) || (alu_op_i == ALU_MUL);
        instr_o = {opF7, rs2_i, rs1_i, aluF3, rd_i, OPC_OP};
      end
      CLS_LOAD: begin
        legal_o = fits_signed(imm_i, 12);
        instr_o = {imm_i[11:0], rs1_i, F3_WORD, rd_i, OPC_LOAD};
      end
      CLS_STORE: begin
        legal_o = fits_signed(imm_i, 12);
        instr_o = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OPC_STORE};
      end
      CLS_BRANCH: begin
        // funct3 010/011 are unassigned branch encodings.
        legal_o = (br_f3_i != 3'b010) && (br_f3_i != 3'b011) && !imm_i[0] &&
                  fits_signed(imm_i, 13);
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, br_f3_i,
                   imm_i[4:1], imm_i[11], OPC_BRANCH};
      end
      CLS_JAL: begin
        legal_o = !imm_i[0] && fits_signed(imm_i, 21);
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
      end
      CLS_JALR: begin
        legal_o = fits_signed(imm_i, 12);
        instr_o = {imm_i[11:0], rs1_i, F3_ADD, rd_i, OPC_JALR};
      end
      default: begin
        legal_o = 1'b0;
        instr_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_enc.sv
// Instruction encoder and IMEM program loader: packs field bundles into RV32 words
// and streams them out with consecutive byte addresses starting at base_addr_i.
module riscv_enc
  import riscv_enc_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic          stop_i,
  riscv_enc_if.slave    enc_if,
  output logic          err_o,
  output logic [7:0]    err_count_o,
  output logic          done_o,
  output logic          busy_o
);

  localparam int CW = $clog2(DEPTH + 1);

  enc_state_e    state_q, state_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] wordCnt_q, wordCnt_d;
  logic          outValid_q, outValid_d;
  logic [31:0]   outInstr_q, outInstr_d;
  logic [AW-1:0] outAddr_q, outAddr_d;
  logic          err_q, err_d;
  logic [7:0]    errCnt_q, errCnt_d;
  logic          done_q, done_d;

  logic [31:0]   packInstr;
  logic          packLegal;
  logic          encReady;
  logic          accept;

  riscv_enc_pack u_pack (
    .cls_i    (enc_if.enc_cls),
    .alu_op_i (enc_if.enc_alu_op),
    .br_f3_i  (enc_if.enc_br_f3),
    .rd_i     (enc_if.enc_rd),
    .rs1_i    (enc_if.enc_rs1),
    .rs2_i    (enc_if.enc_rs2),
    .imm_i    (enc_if.enc_imm),
    .instr_o  (packInstr),
    .legal_o  (packLegal)
  );

  // stop masks ready so a bundle offered alongside it is never consumed.
  assign encReady = (state_q == ST_RUN) && !stop_i && (!outValid_q || enc_if.out_ready);
  assign accept   = enc_if.enc_valid && encReady;

  always_comb begin
    state_d    = state_q;
    wrPtr_d    = wrPtr_q;
    wordCnt_d  = wordCnt_q;
    outValid_d = outValid_q;
    outInstr_d = outInstr_q;
    outAddr_d  = outAddr_q;
    err_d      = 1'b0;
    errCnt_d   = errCnt_q;
    done_d     = 1'b0;

    if (outValid_q && enc_if.out_ready) outValid_d = 1'b0;

    if (accept) begin
      if (packLegal) begin
        outValid_d = 1'b1;
        outInstr_d = packInstr;
        outAddr_d  = wrPtr_q;
        wrPtr_d    = wrPtr_q + AW'(4);
        wordCnt_d  = wordCnt_q + CW'(1);
      end else begin
        err_d = 1'b1;
        if (errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_RUN;
          wrPtr_d   = base_addr_i;
          wordCnt_d = '0;
        end
      end
      ST_RUN: begin
        if (stop_i) state_d = ST_DRAIN;
        else if (wordCnt_d == CW'(DEPTH)) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (stop_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!outValid_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wrPtr_q    <= '0;
      wordCnt_q  <= '0;
      outValid_q <= 1'b0;
      outInstr_q <= '0;
      outAddr_q  <= '0;
      err_q      <= 1'b0;
      errCnt_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      wordCnt_q  <= wordCnt_d;
      outValid_q <= outValid_d;
      outInstr_q <= outInstr_d;
      outAddr_q  <= outAddr_d;
      err_q      <= err_d;
      errCnt_q   <= errCnt_d;
      done_q     <= done_d;
    end
  end

  assign enc_if.enc_ready = encReady;
  assign enc_if.out_valid = outValid_q;
  assign enc_if.out_instr = outInstr_q;
  assign enc_if.out_addr  = outAddr_q;
  assign err_o            = err_q;
  assign err_count_o      = errCnt_q;
  assign done_o           = done_q;
  assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_riscv_enc.sv
// Scoreboard bench for riscv_enc: directed bundles push expected words, a negedge
// monitor pops and compares every word the encoder hands over.
module tb_riscv_enc;
  import riscv_enc_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } word_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] baseAddr;
  logic        stop;
  logic        err;
  logic [7:0]  errCount;
  logic        done;
  logic        busy;

  riscv_enc_if #(.AW(32)) bus ();

  riscv_enc #(.DEPTH(4), .AW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .base_addr_i (baseAddr),
    .stop_i      (stop),
    .enc_if      (bus),
    .err_o       (err),
    .err_count_o (errCount),
    .done_o      (done),
    .busy_o      (busy)
  );

  word_t       sbQ[$];
  word_t       expWord;
  int          compared   = 0;
  int          mismatched = 0;
  int          errSeen    = 0;
  logic [31:0] expAddr    = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change #1 after posedge; the monitor samples on negedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (err) errSeen++;
      if (bus.out_valid && bus.out_ready) begin
        if (sbQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected word: got 0x%08h @0x%08h, expected none",
                   bus.out_instr, bus.out_addr);
        end else begin
          expWord = sbQ.pop_front();
          checkOutput("word instr", bus.out_instr, expWord.instr);
          checkOutput("word addr", bus.out_addr, expWord.addr);
        end
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [2:0] cls, input logic [3:0] aluOp,
                               input logic [2:0] brF3, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm,
                               input logic expLegal, input logic [31:0] expInstr);
    bit accepted = 0;
    bus.enc_cls    = cls;
    bus.enc_alu_op = aluOp;
    bus.enc_br_f3  = brF3;
    bus.enc_rd     = rd;
    bus.enc_rs1    = rs1;
    bus.enc_rs2    = rs2;
    bus.enc_imm    = imm;
    bus.enc_valid  = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (bus.enc_ready) begin
        accepted = 1;
        if (expLegal) begin
          sbQ.push_back({expInstr, expAddr});
          expAddr = expAddr + 32'd4;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.enc_valid = 1'b0;
    if (!accepted) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s accept: got no enc_ready within 20 cycles, expected accept", name);
    end
  endtask

  task automatic startProgram(input logic [31:0] base);
    start    = 1'b1;
    baseAddr = base;
    @(posedge clk);
    #1;
    start   = 1'b0;
    expAddr = base;
  endtask

  task automatic stopAndWaitDone(input string name);
    bit gotDone = 0;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        gotDone = 1;
        break;
      end
    end
    checkOutput({name, " done pulse"}, 32'(gotDone), 32'd1);
    checkOutput({name, " busy after done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({name, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int readySeen;
    rst            = 1'b1;
    start          = 1'b0;
    stop           = 1'b0;
    baseAddr       = '0;
    bus.enc_valid  = 1'b0;
    bus.enc_cls    = '0;
    bus.enc_alu_op = '0;
    bus.enc_br_f3  = '0;
    bus.enc_rd     = '0;
    bus.enc_rs1    = '0;
    bus.enc_rs2    = '0;
    bus.enc_imm    = '0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset enc_ready", 32'(bus.enc_ready), 32'd0);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset out_instr", bus.out_instr, 32'd0);
    checkOutput("reset out_addr", bus.out_addr, 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset err_count", 32'(errCount), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Program 1: basic encodings, rejects, then fill to DEPTH=4.
    startProgram(32'h100);
    checkOutput("busy in RUN", 32'(busy), 32'd1);
    applyStimulus("ADDI", CLS_OPIMM, ALU_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
    applyStimulus("SUB", CLS_OP, ALU_SUB, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3);
    applyStimulus("ADDI 2048", CLS_OPIMM, ALU_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'd0);
    applyStimulus("BRANCH odd", CLS_BRANCH, ALU_ADD, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("err pulses", 32'(errSeen), 32'd2);
    checkOutput("err_count", 32'(errCount), 32'd2);
    applyStimulus("STORE", CLS_STORE, ALU_ADD, 3'd0, 5'd9, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020A423);
    applyStimulus("BRANCH", CLS_BRANCH, ALU_ADD, 3'd0, 5'd9, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3);
    bus.enc_cls   = CLS_JAL;
    bus.enc_rd    = 5'd1;
    bus.enc_imm   = 32'd8;
    bus.enc_valid = 1'b1;
    readySeen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.enc_ready) readySeen++;
    end
    @(posedge clk);
    #1;
    bus.enc_valid = 1'b0;
    checkOutput("FULL refuses 5th", 32'(readySeen), 32'd0);
    checkOutput("busy in FULL", 32'(busy), 32'd1);
    stopAndWaitDone("prog1");

    // Program 2: backpressure hold, then remaining formats.
    startProgram(32'h200);
    bus.out_ready = 1'b0;
    applyStimulus("LOAD", CLS_LOAD, ALU_ADD, 3'd0, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF12283);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold enc_ready", 32'(bus.enc_ready), 32'd0);
      checkOutput("hold out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold out_instr", bus.out_instr, 32'hFFF12283);
      checkOutput("hold out_addr", bus.out_addr, 32'h200);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    applyStimulus("SLLI", CLS_OPIMM, ALU_SLL, 3'd0, 5'd4, 5'd3, 5'd0, 32'd7, 1'b1, 32'h00719213);
    applyStimulus("MUL", CLS_OP, ALU_MUL, 3'd0, 5'd7, 5'd5, 5'd6, 32'd0, 1'b1, 32'h026283B3);
    applyStimulus("JALR", CLS_JALR, ALU_ADD, 3'd0, 5'd1, 5'd5, 5'd0, 32'd0, 1'b1, 32'h000280E7);
    stopAndWaitDone("prog2");

    // Program 3: reset with a word pending, then restart at a new base.
    startProgram(32'h300);
    bus.out_ready = 1'b0;
    applyStimulus("JAL", CLS_JAL, ALU_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h008000EF);
    checkOutput("pending out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("pending out_instr", bus.out_instr, 32'h008000EF);
    checkOutput("err_count before rst", 32'(errCount), 32'd2);
    sbQ.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst out_instr", bus.out_instr, 32'd0);
    checkOutput("rst out_addr", bus.out_addr, 32'd0);
    checkOutput("rst err_count", 32'(errCount), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst enc_ready", 32'(bus.enc_ready), 32'd0);
    bus.out_ready = 1'b1;
    startProgram(32'h400);
    applyStimulus("ADDI restart", CLS_OPIMM, ALU_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
    stopAndWaitDone("prog3");

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
